// File: rtl/multiplier_unit_seq_if.sv
// rtl/multiplier_unit_seq_if.sv - start/busy/done handshake bundle for the iterative multiplier
//
// Purpose: groups the execute-stage request (start, operands, op) and the
//          multiplier response (busy, done, result) into one port.
// Signals:
//   start  - request, sampled by the multiplier only while idle
//   A      - multiplicand (rs1)
//   B      - multiplier (rs2)
//   op     - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   busy   - operation in flight, execute stage stalls
//   done   - one-cycle completion pulse
//   result - selected product half, held until the next completion
// Modports:
//   master - execute stage side (drives request, observes response)
//   slave  - multiplier side
interface multiplier_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start,
    output A,
    output B,
    output op,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    input  op,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/multiplier_unit_seq.sv
// rtl/multiplier_unit_seq.sv - iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
//
// Purpose: computes one RV32M multiply per request using a single 2*WIDTH-bit
//          adder over WIDTH iterations, plus one fix-up cycle for sign and
//          half selection. Latency is fixed and independent of the operands.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, aborts any operation in flight
//   bus   - slave side of multiplier_unit_seq_if (start/A/B/op in,
//           busy/done/result out)
module multiplier_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multiplier_unit_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               last_iter;
  logic [2*WIDTH-1:0] product;

  // Operand signedness depends on op; MUL takes the low half, which is the
  // same for signed and unsigned interpretations, so it is treated as unsigned.
  always_comb begin
    sign_a    = bus.A[WIDTH-1] & ((bus.op == OP_MULH) | (bus.op == OP_MULHSU));
    sign_b    = bus.B[WIDTH-1] & (bus.op == OP_MULH);
    mag_a     = sign_a ? -bus.A : bus.A;
    mag_b     = sign_b ? -bus.B : bus.B;
    last_iter = (count == LAST_ITER);
    product   = neg_q ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      count    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // done is a single-cycle pulse; only FIX raises it.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // |0x80000000| stays 0x80000000 as an unsigned magnitude, which
            // the zero-extended 2*WIDTH-bit path carries without overflow.
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            op_q   <= bus.op;
            neg_q  <= sign_a ^ sign_b;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        FIX: begin
          result_q <= (op_q == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_multiplier_unit_seq.sv
// tb/tb_multiplier_unit_seq.sv - directed vector bench for multiplier_unit_seq
module tb_multiplier_unit_seq;

  logic clk;
  logic rst_n;

  multiplier_unit_seq_if #(.WIDTH(32)) m ();

  multiplier_unit_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  int n_cmp;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request from the current (post-edge) sample point and waits
  // for done. lat counts clock edges after the start edge up to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    logic [31:0] prev;
    logic        moved;
    prev    = m.result;
    moved   = 1'b0;
    m.start = 1'b1;
    m.op    = o;
    m.A     = a;
    m.B     = b;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.A     = $urandom;
    m.B     = $urandom;
    m.op    = 2'($urandom);
    check("busy_rise", 32'(m.busy), 32'd1);
    lat = 0;
    while (!m.done && lat < 100) begin
      if (m.result !== prev) moved = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("result_hold_calc", 32'(moved), 32'd0);
    check("busy_fall_at_done", 32'(m.busy), 32'd0);
    res = m.result;
  endtask

  vec_t        vecs [16];
  logic [31:0] res;
  int          lat;
  int          lat2;
  logic        seen;

  initial begin
    vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[7]  = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
    vecs[9]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
    vecs[10] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[11] = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[13] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[14] = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
    vecs[15] = '{2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002};

    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    m.start = 1'b0;
    m.A     = '0;
    m.B     = '0;
    m.op    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(m.busy), 32'd0);
    check("reset_done", 32'(m.done), 32'd0);
    check("reset_result", m.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_low", i), 32'(m.done), 32'd0);
      check($sformatf("vec%0d_result_held", i), m.result, vecs[i].exp);
    end

    // start pulsed mid-operation must be ignored
    m.start = 1'b1; m.op = 2'b00; m.A = 32'd7; m.B = 32'd6;
    @(posedge clk); #1;
    m.start = 1'b0;
    lat = 0;
    while (!m.done && lat < 100) begin
      m.start = (lat == 9);
      m.A     = 32'd3;
      m.B     = 32'd3;
      @(posedge clk); #1;
      lat++;
    end
    m.start = 1'b0;
    check("ignored_start_latency", 32'(lat), 32'd33);
    check("ignored_start_result", m.result, 32'h0000_002A);

    // back-to-back: start raised in the done cycle
    m.start = 1'b1; m.op = 2'b00; m.A = 32'd3; m.B = 32'd3;
    @(posedge clk); #1;
    m.start = 1'b0;
    lat2 = 1;
    while (!m.done && lat2 < 100) begin
      @(posedge clk); #1;
      lat2++;
    end
    check("b2b_latency", 32'(lat2), 32'd34);
    check("b2b_result", m.result, 32'h0000_0009);
    @(posedge clk); #1;

    // asynchronous reset mid-operation
    m.start = 1'b1; m.op = 2'b00; m.A = 32'd7; m.B = 32'd6;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(m.busy), 32'd0);
    check("abort_done", 32'(m.done), 32'd0);
    check("abort_result", m.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (m.done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_still_idle", 32'(m.busy), 32'd0);

    run_op(2'b00, 32'd2, 32'd5, res, lat);
    check("after_reset_latency", 32'(lat), 32'd33);
    check("after_reset_result", res, 32'h0000_000A);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier_unit_seq.md
Name: multiplier_unit_seq

Overview:
Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU operations. It is the multiply counterpart of the combinational divider in the M-extension datapath. It takes a start/busy/done handshake from the execute stage, which stalls while busy is high. It uses one adder instead of a full array, trading latency for area.

Parameters:
WIDTH, 32, operand and result width; product internally 2*WIDTH bits; iteration counter is clog2(WIDTH)+1 bits.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
A  input  WIDTH  multiplicand (rs1).
B  input  WIDTH  multiplier (rs2).
op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
busy  output  1  high while an operation is in flight; pipeline stalls.
done  output  1  one-cycle pulse; result valid that cycle and held afterwards.
result  output  WIDTH  selected product half.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0.
  - Counter, accumulator and latched operands are cleared.
  - Reset mid-operation aborts it; no done pulse is produced.
- Signedness per op:
  - MUL: product low half; sign irrelevant, computed as unsigned.
  - MULH: A signed, B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both unsigned.
- Operand capture:
  - Signed operands are converted to magnitude (two's-complement negate if MSB=1).
  - neg_flag = signA_eff XOR signB_eff.
- States IDLE, CALC, FIX:
  - IDLE: on a rising edge with start=1:
    - Latch |A| into the multiplicand register, zero-extended to 2*WIDTH.
    - Latch |B| into the multiplier shift register.
    - Latch op and neg_flag.
    - acc=0, count=0, busy<=1, go to CALC.
  - CALC, each edge:
    - If the multiplier LSB=1, acc += multiplicand.
    - Multiplicand <<= 1, multiplier >>= 1, count++.
    - After the WIDTH-th iteration (count reaches WIDTH), go to FIX.
  - FIX, one edge:
    - Negate acc (2*WIDTH-bit two's complement) if neg_flag.
    - result <= low half for MUL, else high half.
    - done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency (start sampled at edge 0):
  - busy rises after edge 0.
  - done is high in the cycle after edge WIDTH+1 (edge 33 for WIDTH=32) and low after the next edge.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start high in the done cycle (state IDLE) is accepted: back-to-back ops with no bubble.
  - A, B and op may change freely after the start edge.
- result holds its value until the next FIX; it does not change during CALC.
- No early termination: latency is fixed and data-independent.
- Corner cases:
  - 0x80000000 magnitude is 0x80000000 as unsigned; the 64-bit accumulator holds it without overflow.
  - Multiply by zero still takes the full latency.

Test Plan:
- MUL A=7, B=6, start 1 cycle -> busy for 33 cycles; done pulses 1 cycle after edge 33; result=0x0000002A.
- MULH A=0xFFFFFFFF, B=0xFFFFFFFF -> result=0x00000000; repeat with MUL -> 0x00000001.
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> product 0xFFFFFFFF00000001; result=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- MULH A=0x80000000, B=0x80000000 -> result=0x40000000; MUL -> 0x00000000.
- Pulse start again with A=3, B=3 at cycle 10 of an in-flight MUL 7*6 -> ignored; that op still returns 0x2A. Then a start in the done cycle with MUL 3*3 -> second done exactly 34 cycles later, result=0x00000009.
- Drop rst_n at cycle 15 of an operation -> busy, done and result go to 0 immediately; no done pulse follows; a new MUL 2*5 after release returns 0x0000000A.
